// File: rtl/branch_ctrl_pkg.sv
// branch_ctrl_pkg: shared opcodes, FSM states and defaults for the branch controller
package branch_ctrl_pkg;
    localparam int DEF_WIDTH = 16;
    localparam logic [3:0] BEQ = 4'b0110;
    localparam logic [3:0] BGT = 4'b0100;
    localparam logic [3:0] BLT = 4'b0101;
    typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_t;
    function automatic logic is_branch(input logic [3:0] op);
        return op == BEQ || op == BGT || op == BLT;
    endfunction
endpackage

// File: rtl/branch_cond.sv
// branch_cond: unsigned compare of the forwarded operands for the selected branch opcode
module branch_cond import branch_ctrl_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] r0,
    input  logic [WIDTH-1:0] r1,
    output logic             taken
);
    // evaluate the branch condition; unknown opcodes are never taken
    always_comb begin
        taken = (opcode == BEQ) ? (r1 == r0) :
                (opcode == BGT) ? (r1 > r0) :
                (opcode == BLT) ? (r1 < r0) : 1'b0;
    end
endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: resolves ID-stage branches, stalls on late operands, redirects the PC on taken
module branch_ctrl import branch_ctrl_pkg::*; #(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int WAIT_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_opcode,
    input  logic [WIDTH-1:0] id_r0,
    input  logic [WIDTH-1:0] id_r1,
    input  logic [WIDTH-1:0] id_pc,
    input  logic [WIDTH-1:0] id_offset,
    input  logic             opnd_ready,
    output logic             stall,
    output logic             flush,
    output logic             pc_sel,
    output logic [WIDTH-1:0] pc_target,
    output logic [15:0]      branch_cnt,
    output logic [15:0]      taken_cnt,
    output logic             err
);
    localparam int WW = $clog2(WAIT_MAX + 1);
    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic          br, taken, active, resolve, timeout;
    branch_cond #(.WIDTH(WIDTH)) u_cond (
        .opcode(id_opcode),
        .r0    (id_r0),
        .r1    (id_r1),
        .taken (taken)
    );
    // decode the current cycle: resolve, time out, or hold the front end
    always_comb begin
        br      = id_valid && is_branch(id_opcode);
        active  = state != FLUSH;
        resolve = active && br && opnd_ready;
        timeout = state == WAIT && br && !opnd_ready && wait_cnt == WW'(WAIT_MAX - 1);
        stall   = !rst && active && br && !opnd_ready && !timeout;
    end
    // FSM, registered redirect, saturating counters and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            flush      <= 1'b0;
            pc_sel     <= 1'b0;
            pc_target  <= '0;
            branch_cnt <= '0;
            taken_cnt  <= '0;
            err        <= 1'b0;
        end else begin
            state    <= (resolve && taken) ? FLUSH : stall ? WAIT : IDLE;
            wait_cnt <= (state == IDLE) ? '0 : stall ? wait_cnt + 1'b1 : wait_cnt;
            flush    <= resolve && taken;
            pc_sel   <= resolve && taken;
            if (resolve && taken)
                pc_target <= id_pc + id_offset;
            if (resolve && branch_cnt != 16'hFFFF)
                branch_cnt <= branch_cnt + 16'd1;
            if (resolve && taken && taken_cnt != 16'hFFFF)
                taken_cnt <= taken_cnt + 16'd1;
            if (timeout)
                err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: table-driven and sequence checks of branch_ctrl against a scoreboard model
module tb_branch_ctrl;
    import branch_ctrl_pkg::*;
    localparam int W  = 16;
    localparam int WM = 4;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         id_valid = 1'b0, opnd_ready = 1'b1;
    logic [3:0]   id_opcode = '0;
    logic [W-1:0] id_r0 = '0, id_r1 = '0, id_pc = '0, id_offset = '0;
    logic         stall, flush, pc_sel, err;
    logic [W-1:0] pc_target;
    logic [15:0]  branch_cnt, taken_cnt;
    int total = 0;
    int bad   = 0;
    typedef struct {logic fl; logic [W-1:0] tgt; logic [15:0] bc; logic [15:0] tc;} exp_t;
    typedef struct {logic [3:0] op; logic [W-1:0] r0; logic [W-1:0] r1; logic [W-1:0] pc; logic [W-1:0] off; logic br; logic tk;} vec_t;
    exp_t         sb[$];
    vec_t         vecs[9];
    logic [W-1:0] m_tgt = '0;
    logic [15:0]  m_bc = '0, m_tc = '0;

    always #5 clk = ~clk;

    branch_ctrl #(.WIDTH(W), .WAIT_MAX(WM)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_r0(id_r0), .id_r1(id_r1), .id_pc(id_pc), .id_offset(id_offset),
        .opnd_ready(opnd_ready), .stall(stall), .flush(flush), .pc_sel(pc_sel),
        .pc_target(pc_target), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt), .err(err)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [W-1:0] r0, r1, pc, off, input logic rdy);
        id_valid = v; id_opcode = op; id_r0 = r0; id_r1 = r1; id_pc = pc; id_offset = off; opnd_ready = rdy;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 4'b0000, '0, '0, '0, '0, 1'b1);
    endtask

    task automatic push(input logic tk, input logic [W-1:0] pc, off);
        if (m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
        if (tk) begin
            if (m_tc != 16'hFFFF) m_tc = m_tc + 16'd1;
            m_tgt = pc + off;
        end
        sb.push_back('{tk, m_tgt, m_bc, m_tc});
    endtask

    task automatic pop_check(input string n);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard empty", n);
            return;
        end
        e = sb.pop_front();
        chk({n, "_flush"}, flush, e.fl);
        chk({n, "_pcsel"}, pc_sel, e.fl);
        chk({n, "_tgt"}, pc_target, e.tgt);
        chk({n, "_bcnt"}, branch_cnt, e.bc);
        chk({n, "_tcnt"}, taken_cnt, e.tc);
    endtask

    task automatic do_branch(input string n, input logic [3:0] op, input logic [W-1:0] r0, r1, pc, off, input logic br, tk);
        drive(1'b1, op, r0, r1, pc, off, 1'b1);
        chk({n, "_stall"}, stall, 1'b0);
        if (br) push(tk, pc, off);
        tick();
        idle();
        if (br) pop_check(n);
        else begin
            chk({n, "_nb_flush"}, flush, 1'b0);
            chk({n, "_nb_bcnt"}, branch_cnt, m_bc);
        end
        tick();
        chk({n, "_flush_clr"}, flush, 1'b0);
        chk({n, "_pcsel_clr"}, pc_sel, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vecs = '{
            '{BEQ,     16'h1234, 16'h1234, 16'h0010, 16'h0004, 1'b1, 1'b1},
            '{BLT,     16'h0003, 16'h0005, 16'h0020, 16'h0008, 1'b1, 1'b0},
            '{BGT,     16'h0002, 16'h0009, 16'h0100, 16'hFFFC, 1'b1, 1'b1},
            '{BEQ,     16'h0001, 16'h0002, 16'h0030, 16'h0004, 1'b1, 1'b0},
            '{BLT,     16'h0009, 16'h0003, 16'hFFF0, 16'h0020, 1'b1, 1'b1},
            '{BGT,     16'h0005, 16'h0005, 16'h0040, 16'h0004, 1'b1, 1'b0},
            '{BLT,     16'h0005, 16'h0005, 16'h0050, 16'h0004, 1'b1, 1'b0},
            '{BGT,     16'h0000, 16'hFFFF, 16'h1000, 16'h0001, 1'b1, 1'b1},
            '{4'b0111, 16'h0007, 16'h0007, 16'h2000, 16'h0010, 1'b0, 1'b0}
        };
        #1 rst = 1'b1;
        #2;
        chk("rst_stall", stall, 1'b0);
        chk("rst_flush", flush, 1'b0);
        chk("rst_pcsel", pc_sel, 1'b0);
        chk("rst_tgt", pc_target, '0);
        chk("rst_bcnt", branch_cnt, '0);
        chk("rst_tcnt", taken_cnt, '0);
        chk("rst_err", err, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        foreach (vecs[i])
            do_branch($sformatf("vec%0d", i), vecs[i].op, vecs[i].r0, vecs[i].r1, vecs[i].pc, vecs[i].off, vecs[i].br, vecs[i].tk);
        // bgt with operands late for two cycles
        drive(1'b1, BGT, 16'h0002, 16'h0009, 16'h0200, 16'h0010, 1'b0);
        chk("late_stall0", stall, 1'b1);
        tick();
        chk("late_stall1", stall, 1'b1);
        opnd_ready = 1'b1;
        #1;
        chk("late_stall2", stall, 1'b0);
        push(1'b1, 16'h0200, 16'h0010);
        tick();
        idle();
        pop_check("late");
        tick();
        chk("late_flush_clr", flush, 1'b0);
        // branch held through FLUSH is squashed
        drive(1'b1, BEQ, 16'h0042, 16'h0042, 16'h0300, 16'h0008, 1'b1);
        push(1'b1, 16'h0300, 16'h0008);
        tick();
        pop_check("sq");
        chk("sq_stall", stall, 1'b0);
        tick();
        idle();
        chk("sq_flush_clr", flush, 1'b0);
        chk("sq_bcnt", branch_cnt, m_bc);
        chk("sq_tcnt", taken_cnt, m_tc);
        tick();
        // abandon a waiting branch
        drive(1'b1, BGT, 16'h0001, 16'h0008, 16'h0400, 16'h0004, 1'b0);
        tick();
        chk("ab_wait_stall", stall, 1'b1);
        idle();
        chk("ab_stall", stall, 1'b0);
        tick();
        chk("ab_flush", flush, 1'b0);
        chk("ab_bcnt", branch_cnt, m_bc);
        // operands never arrive: timeout
        drive(1'b1, BEQ, 16'h0001, 16'h0001, 16'h0500, 16'h0004, 1'b0);
        for (int i = 0; i < WM; i++) begin
            chk($sformatf("to_stall%0d", i), stall, 1'b1);
            tick();
        end
        chk("to_stall_end", stall, 1'b0);
        chk("to_err_pre", err, 1'b0);
        tick();
        idle();
        chk("to_err", err, 1'b1);
        chk("to_flush", flush, 1'b0);
        chk("to_bcnt", branch_cnt, m_bc);
        chk("to_tcnt", taken_cnt, m_tc);
        tick();
        chk("to_err_sticky", err, 1'b1);
        // async reset in the middle of WAIT
        drive(1'b1, BGT, 16'h0002, 16'h0009, 16'h0600, 16'h0004, 1'b0);
        tick();
        chk("mr_stall_pre", stall, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mr_stall", stall, 1'b0);
        chk("mr_tgt", pc_target, '0);
        chk("mr_bcnt", branch_cnt, '0);
        chk("mr_tcnt", taken_cnt, '0);
        chk("mr_err", err, 1'b0);
        idle();
        m_bc = '0; m_tc = '0; m_tgt = '0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("mr_flush_post", flush, 1'b0);
        chk("mr_pcsel_post", pc_sel, 1'b0);
        chk("mr_bcnt_post", branch_cnt, '0);
        // counter saturation from a near-full preload
        force dut.branch_cnt = 16'hFFFE;
        force dut.taken_cnt  = 16'hFFFE;
        #1;
        release dut.branch_cnt;
        release dut.taken_cnt;
        m_bc = 16'hFFFE; m_tc = 16'hFFFE;
        do_branch("sat0", BEQ, 16'h0005, 16'h0005, 16'h0700, 16'h0010, 1'b1, 1'b1);
        do_branch("sat1", BEQ, 16'h0006, 16'h0006, 16'h0800, 16'h0020, 1'b1, 1'b1);
        do_branch("sat2", BLT, 16'h0006, 16'h0001, 16'h0900, 16'h0030, 1'b1, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
